// File: rtl/pulse_sync_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : pulse_sync_tx
// Description : Source-side transmitter of a toggle-handshake pulse crossing.
//               Each launched event flips req_toggle. The receiver answers by
//               flipping ack_toggle, which is synchronized back here. Events
//               that arrive while a transfer is in flight are queued in a
//               saturating counter. Events that cannot be queued are dropped
//               and flagged on the sticky overflow output.
// Build option: PULSE_SYNC_TX_QUEUE_EN
//               - defined:   pending-event counter and queueing are enabled.
//               - undefined: there is no queue. pend_cnt is tied to 0. A pulse
//                            in WAIT_ACK that is not launched is dropped.
// Ports       :
//   src_clk     in   source clock, rising edge
//   src_rst_n   in   asynchronous active-low reset
//   src_pulse   in   event input, one event per high cycle
//   ack_toggle  in   asynchronous acknowledge toggle from the receiver
//   ovf_clr     in   clears overflow. A coincident set has priority.
//   req_toggle  out  request level, driven directly from a flop
//   busy        out  high while a transfer awaits acknowledge
//   pend_cnt    out  events accepted but not yet launched
//   overflow    out  sticky dropped-event flag
// Revision    : 1.0  initial release
// ============================================================================
module pulse_sync_tx #(
  parameter int SYNC_STAGES = 2,
  parameter int PEND_W      = 4
) (
  input  logic              src_clk,
  input  logic              src_rst_n,
  input  logic              src_pulse,
  input  logic              ack_toggle,
  input  logic              ovf_clr,
  output logic              req_toggle,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              overflow
);

  localparam logic [0:0] c_IDLE     = 1'b0;
  localparam logic [0:0] c_WAIT_ACK = 1'b1;

  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic [0:0]             r_state;
  logic [0:0]             w_state_nxt;
  logic                   r_req;
  logic                   r_ovf;
  logic                   w_ack_sync;
  logic                   w_done;
  logic                   w_launch;
  logic                   w_drop;
  logic                   w_work;

  // Synchronizer chain for the acknowledge toggle. Only the last stage is
  // used by the control logic.
  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) begin
      r_ack_sync <= '0;
    end else begin
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack_toggle};
    end
  end

  assign w_ack_sync = r_ack_sync[SYNC_STAGES-1];
  // The receiver has caught up once its acknowledge phase matches the request.
  assign w_done     = (w_ack_sync == r_req);

`ifdef PULSE_SYNC_TX_QUEUE_EN
  localparam logic [PEND_W-1:0] c_PEND_MAX = '1;

  logic [PEND_W-1:0] r_pend;
  logic [PEND_W-1:0] w_pend_nxt;
  logic              w_pend_any;

  assign w_pend_any = (r_pend != '0);
  assign w_work     = src_pulse | w_pend_any;

  always_comb begin
    w_launch    = 1'b0;
    w_drop      = 1'b0;
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    if (r_state == c_IDLE) begin
      if (w_work) begin
        w_launch    = 1'b1;
        w_state_nxt = c_WAIT_ACK;
      end
    end else begin
      if (w_done) begin
        if (w_work) begin
          w_launch = 1'b1;
        end else begin
          w_state_nxt = c_IDLE;
        end
      end else if (src_pulse) begin
        if (r_pend != c_PEND_MAX) begin
          w_pend_nxt = r_pend + PEND_W'(1);
        end else begin
          w_drop = 1'b1;
        end
      end
    end
    // A launch consumes a queued event unless a fresh pulse takes its place
    // in the same cycle. In that case the count is unchanged.
    if (w_launch && w_pend_any && !src_pulse) begin
      w_pend_nxt = r_pend - PEND_W'(1);
    end
  end

  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_nxt;
    end
  end

  assign pend_cnt = r_pend;
`else
  assign w_work = src_pulse;

  always_comb begin
    w_launch    = 1'b0;
    w_drop      = 1'b0;
    w_state_nxt = r_state;
    if (r_state == c_IDLE) begin
      if (w_work) begin
        w_launch    = 1'b1;
        w_state_nxt = c_WAIT_ACK;
      end
    end else begin
      if (w_done) begin
        if (w_work) begin
          w_launch = 1'b1;
        end else begin
          w_state_nxt = c_IDLE;
        end
      end else if (src_pulse) begin
        w_drop = 1'b1;
      end
    end
  end

  assign pend_cnt = '0;
`endif

  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) begin
      r_state <= c_IDLE;
      r_req   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_launch) begin
        r_req <= ~r_req;
      end
      // A drop has priority over a clear in the same cycle.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign req_toggle = r_req;
  assign busy       = (r_state == c_WAIT_ACK);
  assign overflow   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pulse_sync_tx.sv
`default_nettype none
`timescale 1ns/1ps
module tb_pulse_sync_tx;

  localparam int c_SYNC   = 2;
  localparam int c_PEND_W = 2;

  logic src_clk    = 1'b0;
  logic src_rst_n  = 1'b0;
  logic src_pulse  = 1'b0;
  logic ack_toggle = 1'b0;
  logic ovf_clr    = 1'b0;
  logic req_toggle;
  logic busy;
  logic overflow;
  logic [c_PEND_W-1:0] pend_cnt;

  typedef struct {
    logic                req;
    logic [c_PEND_W-1:0] pend;
  } exp_t;

  exp_t sb[$];
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   n_toggles = 0;
  int   tog_base  = 0;
  logic exp_req   = 1'b0;
  logic prev_req  = 1'b0;

  always #5 src_clk = ~src_clk;

  pulse_sync_tx #(
    .SYNC_STAGES (c_SYNC),
    .PEND_W      (c_PEND_W)
  ) dut (
    .src_clk    (src_clk),
    .src_rst_n  (src_rst_n),
    .src_pulse  (src_pulse),
    .ack_toggle (ack_toggle),
    .ovf_clr    (ovf_clr),
    .req_toggle (req_toggle),
    .busy       (busy),
    .pend_cnt   (pend_cnt),
    .overflow   (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected launch: next request phase and pend_cnt right after the launch edge.
  task automatic push_launch(input int p);
    exp_t e;
    exp_req = ~exp_req;
    e.req   = exp_req;
    e.pend  = c_PEND_W'(p);
    sb.push_back(e);
  endtask

  // Receiver model: acknowledge the current request, then let the sync
  // chain (2 edges) and the acting edge pass.
  task automatic ack_round(input bit launch, input int p);
    ack_toggle = exp_req;
    if (launch) push_launch(p);
    repeat (3) @(negedge src_clk);
  endtask

  // Monitor: every req_toggle transition must match the oldest expectation.
  always @(negedge src_clk) begin
    if (!src_rst_n) begin
      prev_req = req_toggle;
    end else if (req_toggle !== prev_req) begin
      prev_req = req_toggle;
      n_toggles++;
      check("toggle_expected", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("toggle_req", req_toggle, e.req);
        check("toggle_pend", pend_cnt, e.pend);
      end
    end
  end

  initial begin
    int pend_tbl[5];
    int ovf_tbl[5];
    pend_tbl = '{1, 2, 3, 3, 3};
    ovf_tbl  = '{0, 0, 0, 1, 1};

    repeat (3) @(negedge src_clk);
    check("rst_req", req_toggle, 0);
    check("rst_busy", busy, 0);
    check("rst_pend", pend_cnt, 0);
    check("rst_ovf", overflow, 0);
    src_rst_n = 1'b1;

    // Single event, receiver acknowledges 5 cycles later.
    repeat (6) @(negedge src_clk);
    tog_base  = n_toggles;
    src_pulse = 1'b1;
    push_launch(0);
    @(negedge src_clk);
    src_pulse = 1'b0;
    check("single_busy", busy, 1);
    check("single_req", req_toggle, 1);
    check("single_pend", pend_cnt, 0);
    repeat (4) @(negedge src_clk);
    ack_toggle = exp_req;
    @(negedge src_clk);
    check("single_busy_k", busy, 1);
    @(negedge src_clk);
    check("single_busy_k1", busy, 1);
    @(negedge src_clk);
    check("single_busy_fall", busy, 0);
    check("single_toggles", n_toggles - tog_base, 1);

    // done coincides with a fresh pulse while nothing is pending.
    tog_base  = n_toggles;
    src_pulse = 1'b1;
    push_launch(0);
    @(negedge src_clk);
    src_pulse  = 1'b0;
    ack_toggle = exp_req;
    repeat (2) @(negedge src_clk);
    src_pulse = 1'b1;
    push_launch(0);
    @(negedge src_clk);
    src_pulse = 1'b0;
    check("coinc_busy", busy, 1);
    check("coinc_pend", pend_cnt, 0);
    ack_round(0, 0);
    check("coinc_idle", busy, 0);
    check("coinc_toggles", n_toggles - tog_base, 2);

`ifdef PULSE_SYNC_TX_QUEUE_EN
    // Burst of three consecutive pulses from IDLE.
    tog_base  = n_toggles;
    src_pulse = 1'b1;
    push_launch(0);
    @(negedge src_clk);
    check("burst_pend0", pend_cnt, 0);
    @(negedge src_clk);
    check("burst_pend1", pend_cnt, 1);
    @(negedge src_clk);
    src_pulse = 1'b0;
    check("burst_pend2", pend_cnt, 2);
    ack_round(1, 1);
    check("burst_busy_mid", busy, 1);
    ack_round(1, 0);
    check("burst_busy_last", busy, 1);
    ack_round(0, 0);
    check("burst_idle", busy, 0);
    check("burst_pend_end", pend_cnt, 0);
    check("burst_toggles", n_toggles - tog_base, 3);

    // Saturation: five extra pulses during one WAIT_ACK with depth 3.
    tog_base  = n_toggles;
    src_pulse = 1'b1;
    push_launch(0);
    @(negedge src_clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge src_clk);
      check("sat_pend", pend_cnt, pend_tbl[i]);
      check("sat_ovf", overflow, ovf_tbl[i]);
    end
    src_pulse = 1'b0;
    ack_round(1, 2);
    ack_round(1, 1);
    ack_round(1, 0);
    ack_round(0, 0);
    check("sat_idle", busy, 0);
    check("sat_toggles", n_toggles - tog_base, 4);
    check("sat_ovf_sticky", overflow, 1);
    ovf_clr = 1'b1;
    @(negedge src_clk);
    ovf_clr = 1'b0;
    check("sat_ovf_clr", overflow, 0);
`else
    // No queue: a pulse during WAIT_ACK is dropped. A coincident clear loses.
    tog_base  = n_toggles;
    src_pulse = 1'b1;
    push_launch(0);
    @(negedge src_clk);
    ovf_clr = 1'b1;
    @(negedge src_clk);
    src_pulse = 1'b0;
    ovf_clr   = 1'b0;
    check("drop_ovf", overflow, 1);
    check("drop_pend", pend_cnt, 0);
    check("drop_busy", busy, 1);
    ack_round(0, 0);
    check("drop_idle", busy, 0);
    check("drop_toggles", n_toggles - tog_base, 1);
    ovf_clr = 1'b1;
    @(negedge src_clk);
    ovf_clr = 1'b0;
    check("drop_ovf_clr", overflow, 0);
`endif

    // Asynchronous reset in the middle of WAIT_ACK.
    src_pulse = 1'b1;
    push_launch(0);
    @(negedge src_clk);
    @(negedge src_clk);
`ifdef PULSE_SYNC_TX_QUEUE_EN
    @(negedge src_clk);
    check("rstmid_pend_pre", pend_cnt, 2);
`else
    check("rstmid_ovf_pre", overflow, 1);
`endif
    src_pulse = 1'b0;
    check("rstmid_busy_pre", busy, 1);
    #2;
    src_rst_n  = 1'b0;
    ack_toggle = 1'b0;
    #1;
    check("rstmid_req", req_toggle, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_pend", pend_cnt, 0);
    check("rstmid_ovf", overflow, 0);
    exp_req = 1'b0;
    @(negedge src_clk);
    #2;
    src_rst_n = 1'b1;
    tog_base  = n_toggles;
    repeat (8) @(negedge src_clk);
    check("rstmid_no_toggle", n_toggles - tog_base, 0);
    check("rstmid_idle", busy, 0);

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
